// File: rtl/rv32i_types.sv
// rv32i_types: shared line geometry and write-back buffer FSM state encoding.
package rv32i_types;
  localparam int LINE_OFFSET_W = 5;
  localparam int LINE_W = 256;
  localparam int TAG_W = 32 - LINE_OFFSET_W;
  typedef enum logic [1:0] {IDLE, RESP, READ_MEM, DRAIN} wbbuf_state_t;
endpackage

// File: rtl/wb_store.sv
// wb_store: FIFO-ordered victim line storage with a parallel tag CAM.
module wb_store
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              push_i,
  input  logic              ovw_i,
  input  logic              pop_i,
  output logic              hit_o,
  output logic [LINE_W-1:0] hit_data_o,
  output logic [TAG_W-1:0]  head_tag_o,
  output logic [LINE_W-1:0] head_data_o,
  output logic              empty_o,
  output logic              full_o
);
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [IW-1:0]     head_q, tail_q, hit_idx;
  logic [IW:0]       count_q;
  // tags are kept unique, so at most one entry can match
  always_comb begin
    hit_o = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && tag_q[i] == tag_i) begin
        hit_o = 1'b1;
        hit_idx = IW'(i);
      end
  end
  assign hit_data_o = data_q[hit_idx];
  assign head_tag_o = tag_q[head_q];
  assign head_data_o = data_q[head_q];
  assign empty_o = count_q == '0;
  assign full_o = count_q == (IW+1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) valid_q[tail_q] <= 1'b1;
      if (pop_i) valid_q[head_q] <= 1'b0;
      head_q <= head_q + IW'(pop_i);
      tail_q <= tail_q + IW'(push_i);
      count_q <= count_q + (IW+1)'(push_i) - (IW+1)'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) begin
      tag_q[tail_q] <= tag_i;
      data_q[tail_q] <= data_i;
    end
    if (ovw_i) data_q[hit_idx] <= data_i;
  end
endmodule

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: victim buffer between L2 and the cacheline adaptor; absorbs
// evictions, drains them when idle, serves read hits and lets read misses bypass.
module l2_writeback_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [LINE_W-1:0] mem_wdata256,
  output logic [LINE_W-1:0] mem_rdata256,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              wb_empty
);
  wbbuf_state_t      state_q, state_d;
  logic [LINE_W-1:0] rdata_q, hit_data, head_data;
  logic [TAG_W-1:0]  tag_q, head_tag;
  logic              hit, full, empty, push, ovw, pop;
  logic              unused_offset;
  assign unused_offset = ^mem_address[LINE_OFFSET_W-1:0];
  wb_store #(.DEPTH(DEPTH)) u_store (
    .clk        (clk),
    .reset_n    (reset_n),
    .tag_i      (mem_address[31:LINE_OFFSET_W]),
    .data_i     (mem_wdata256),
    .push_i     (push),
    .ovw_i      (ovw),
    .pop_i      (pop),
    .hit_o      (hit),
    .hit_data_o (hit_data),
    .head_tag_o (head_tag),
    .head_data_o(head_data),
    .empty_o    (empty),
    .full_o     (full)
  );
  always_comb begin
    state_d = state_q;
    push = 1'b0;
    ovw = 1'b0;
    pop = 1'b0;
    case (state_q)
      IDLE:
        if (mem_read) state_d = hit ? RESP : READ_MEM;
        else if (mem_write) begin
          ovw = hit;
          push = !hit && !full;
          state_d = (hit || !full) ? RESP : DRAIN;
        end else if (!empty) state_d = DRAIN;
      RESP: state_d = IDLE;
      READ_MEM: state_d = pmem_resp ? RESP : READ_MEM;
      DRAIN: begin
        pop = pmem_resp;
        state_d = pmem_resp ? IDLE : DRAIN;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) tag_q <= mem_address[31:LINE_OFFSET_W];
      if (state_q == IDLE && mem_read && hit) rdata_q <= hit_data;
      else if (state_q == READ_MEM && pmem_resp) rdata_q <= pmem_rdata;
    end
  end
  assign mem_resp = state_q == RESP;
  assign mem_rdata256 = mem_resp ? rdata_q : '0;
  assign pmem_read = state_q == READ_MEM;
  assign pmem_write = state_q == DRAIN;
  assign pmem_address = pmem_write ? {head_tag, {LINE_OFFSET_W{1'b0}}}
                      : pmem_read ? {tag_q, {LINE_OFFSET_W{1'b0}}} : '0;
  assign pmem_wdata = pmem_write ? head_data : '0;
  assign wb_empty = empty;
  // simultaneous read and write is an L2 protocol violation; read takes priority
  a_no_rw: assert property (@(posedge clk) disable iff (!reset_n) !(mem_read && mem_write));
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: directed scoreboard bench with a latency-programmable adaptor model.
module tb_l2_writeback_buffer;
  logic         clk = 0, reset_n = 0;
  logic [31:0]  mem_address, pmem_address;
  logic         mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp, wb_empty;
  logic [255:0] mem_wdata256, mem_rdata256, pmem_wdata, pmem_rdata;
  int checks = 0, failures = 0, wr_seen = 0, rd_seen = 0, cnt = 0;
  bit stall = 0;
  typedef struct {logic [31:0] a; logic [255:0] d;} line_t;
  line_t drain_q[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  l2_writeback_buffer dut (
    .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256),
    .mem_resp(mem_resp), .pmem_address(pmem_address), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .wb_empty(wb_empty)
  );

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction
  function automatic logic [255:0] dat(input logic [31:0] a);
    return {8{a | 32'hD000_0000}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic l2_req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                        output logic [255:0] rd, output int lat);
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_address = a; mem_wdata256 = d;
    lat = 0;
    while (!mem_resp && lat < 50) begin @(negedge clk); lat++; end
    chk("mem_resp_seen", mem_resp, 1);
    rd = mem_rdata256;
    lat++;
    mem_read = 0; mem_write = 0;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((drain_q.size() != 0 || !wb_empty) && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_wb_empty"}, wb_empty, 1);
    chk({tag, "_drain_q"}, drain_q.size(), 0);
  endtask

  // adaptor model: answers a held request after three unstalled cycles
  initial begin
    line_t e;
    logic [31:0] ea;
    pmem_resp = 0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 0;
      if (!reset_n || !(pmem_read || pmem_write)) cnt = 0;
      else if (!stall) begin
        cnt++;
        if (cnt >= 3) begin
          cnt = 0;
          pmem_resp = 1;
          chk("pmem_exclusive", pmem_read & pmem_write, 0);
          if (pmem_write) begin
            wr_seen++;
            e = drain_q.size() != 0 ? drain_q.pop_front() : '{32'hDEAD_DEAD, '0};
            chk("drain_addr", pmem_address, e.a);
            chk("drain_data", pmem_wdata, e.d);
          end else begin
            rd_seen++;
            ea = rd_q.size() != 0 ? rd_q.pop_front() : 32'hDEAD_DEAD;
            chk("read_addr", pmem_address, ea);
            pmem_rdata = pat(pmem_address);
          end
        end
      end
    end
  end

  initial begin
    logic [255:0] rd;
    int lat, w0, r0;
    mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata256 = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata256, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_wb_empty", wb_empty, 1);
    reset_n = 1;

    drain_q.push_back('{32'h1040, dat(32'h1040)});
    l2_req(1, 32'h1040, dat(32'h1040), rd, lat);
    chk("insert_latency", lat, 2);
    chk("insert_not_empty", wb_empty, 0);
    wait_drained("single");

    r0 = rd_seen;
    l2_req(1, 32'h2000, dat(32'h2000), rd, lat);
    l2_req(0, 32'h201C, '0, rd, lat);
    chk("hit_data", rd, dat(32'h2000));
    chk("hit_latency", lat, 2);
    chk("hit_no_pmem_read", rd_seen, r0);
    drain_q.push_back('{32'h2000, dat(32'h2000)});
    wait_drained("hit");

    stall = 1;
    for (int i = 1; i <= 4; i++) begin
      drain_q.push_back('{32'(i) << 8, dat(32'(i) << 8)});
      l2_req(1, 32'(i) << 8, dat(32'(i) << 8), rd, lat);
      chk("fill_latency", lat, 2);
    end
    drain_q.push_back('{32'h500, dat(32'h500)});
    w0 = wr_seen;
    @(negedge clk);
    mem_write = 1; mem_address = 32'h500; mem_wdata256 = dat(32'h500);
    repeat (3) @(negedge clk);
    chk("forced_drain_write", pmem_write, 1);
    chk("forced_drain_addr", pmem_address, 32'h100);
    chk("forced_no_resp_yet", mem_resp, 0);
    stall = 0;
    lat = 0;
    while (!mem_resp && lat < 50) begin @(negedge clk); lat++; end
    chk("forced_resp", mem_resp, 1);
    chk("forced_one_drain", wr_seen - w0, 1);
    mem_write = 0;
    wait_drained("full");

    w0 = wr_seen;
    l2_req(1, 32'h3000, {8{32'hC0C0_C0C0}}, rd, lat);
    l2_req(1, 32'h3000, {8{32'hD0D0_D0D0}}, rd, lat);
    chk("coalesce_latency", lat, 2);
    drain_q.push_back('{32'h3000, {8{32'hD0D0_D0D0}}});
    wait_drained("coalesce");
    chk("coalesce_one_write", wr_seen - w0, 1);

    l2_req(1, 32'h100, {8{32'hE0E0_E0E0}}, rd, lat);
    drain_q.push_back('{32'h100, {8{32'hE0E0_E0E0}}});
    w0 = wr_seen; r0 = rd_seen;
    rd_q.push_back(32'h900);
    l2_req(0, 32'h900, '0, rd, lat);
    chk("miss_data", rd, pat(32'h900));
    chk("miss_read_issued", rd_seen - r0, 1);
    chk("miss_before_drain", wr_seen - w0, 0);
    stall = 1;
    lat = 0;
    while (!pmem_write && lat < 20) begin @(negedge clk); lat++; end
    chk("bypass_drain_start", pmem_write, 1);
    chk("bypass_drain_addr", pmem_address, 32'h100);
    reset_n = 0;
    @(negedge clk);
    chk("midrst_pmem_write", pmem_write, 0);
    chk("midrst_wb_empty", wb_empty, 1);
    reset_n = 1; stall = 0;
    drain_q.delete();
    repeat (6) @(negedge clk);
    chk("postrst_idle", pmem_write | pmem_read, 0);
    chk("postrst_empty", wb_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
